// File: rtl/kuz_l_transform.sv
// ============================================================================
// kuz_l_transform : iterative Kuznyechik L / L^-1 layer, R_PER_CLK R-steps/clk
// Revision 1.0
// ============================================================================
`default_nettype none

module kuz_l_transform #(
  parameter int R_PER_CLK = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int STEPS = 16 / R_PER_CLK;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  generate
    if (R_PER_CLK != 1 && R_PER_CLK != 2 && R_PER_CLK != 4 &&
        R_PER_CLK != 8 && R_PER_CLK != 16) begin : g_bad_r_per_clk
      $error("kuz_l_transform: R_PER_CLK must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Constant multiply in GF(2^8), p(x) = x^8+x^7+x^6+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'hC3 : 8'h00);
    end
    return acc;
  endfunction

  // l(x15..x0) with x15 in the top byte of the argument.
  function automatic logic [7:0] l_func(input logic [127:0] x);
    return gf_mul(x[127:120], 8'd148) ^ gf_mul(x[119:112], 8'd32)  ^
           gf_mul(x[111:104], 8'd133) ^ gf_mul(x[103:96],  8'd16)  ^
           gf_mul(x[95:88],   8'd194) ^ gf_mul(x[87:80],   8'd192) ^
           x[79:72]                   ^ gf_mul(x[71:64],   8'd251) ^
           x[63:56]                   ^ gf_mul(x[55:48],   8'd192) ^
           gf_mul(x[47:40],   8'd194) ^ gf_mul(x[39:32],   8'd16)  ^
           gf_mul(x[31:24],   8'd133) ^ gf_mul(x[23:16],   8'd32)  ^
           gf_mul(x[15:8],    8'd148) ^ x[7:0];
  endfunction

  // Inverse step rotates a15 to the bottom before evaluating l.
  function automatic logic [127:0] r_step(input logic [127:0] x, input logic mode);
    logic [127:0] res;
    if (!mode) res = {l_func(x), x[127:8]};
    else       res = {x[119:0], l_func({x[119:0], x[127:120]})};
    return res;
  endfunction

  logic [1:0]       state;
  logic [127:0]     s;
  logic             inv;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     chain [0:R_PER_CLK];

  assign chain[0] = s;

  generate
    for (genvar g = 0; g < R_PER_CLK; g++) begin : g_step
      assign chain[g+1] = r_step(chain[g], inv);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      s     <= '0;
      inv   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            s     <= in_data;
            inv   <= in_inv;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          s   <= chain[R_PER_CLK];
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = s;

endmodule

`default_nettype wire

// File: doc/kuz_l_transform.md
# kuz_l_transform

Iterative linear transform L (and inverse L⁻¹) for the Kuznyechik (GOST R 34.12-2015) round datapath. It sits directly downstream of the byte S-box stage `table_convertion_2`. It receives the 128-bit state after 16 parallel S-box substitutions and applies 16 R-steps, the GF(2⁸) LFSR mixing, over multiple clocks. Its result feeds the round-key XOR. Data moves on a valid/ready handshake on both sides.

## Interface
- `R_PER_CLK`, default 1: R-steps per clock. Legal values are 1, 2, 4, 8 and 16. N = 16/R_PER_CLK is the number of compute cycles.
- `clk`, input, 1: sole clock; all flops are rising-edge.
- `rst_n`, input, 1: reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `in_valid`, input, 1: upstream word valid.
- `in_ready`, output, 1: block can accept a word.
- `in_data`, input, 128: state after S-layer. Byte a15 = [127:120], byte a0 = [7:0].
- `in_inv`, input, 1: 0 selects L, 1 selects L⁻¹. Sampled at accept only.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_data`, output, 128: transformed state.

## Operation
- Field arithmetic:
  - GF(2⁸) with p(x) = x⁸+x⁷+x⁶+x+1, reduction constant 0xC3.
  - Multiplication by constants is shift-and-xor. Addition is XOR.
  - All intermediates are 8 bits.
- Linear function l(x15..x0) = 148·x15 ⊕ 32·x14 ⊕ 133·x13 ⊕ 16·x12 ⊕ 194·x11 ⊕ 192·x10 ⊕ 1·x9 ⊕ 251·x8 ⊕ 1·x7 ⊕ 192·x6 ⊕ 194·x5 ⊕ 16·x4 ⊕ 133·x3 ⊕ 32·x2 ⊕ 148·x1 ⊕ 1·x0. All constants are decimal.
- Forward step R: s ← {l(a15..a0), s[127:8]}.
- Inverse step R⁻¹: s ← {s[119:0], l(a14,a13,…,a0,a15)}.
- L = R¹⁶ and L⁻¹ = (R⁻¹)¹⁶.
- Each compute cycle chains R_PER_CLK steps combinationally into the state register.
- Registers: 128-bit state `s`, mode bit `inv`, step counter `cnt` of width log2(N) (minimum 1 bit), and 2-bit FSM.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, load `s`←`in_data` and `inv`←`in_inv`, clear `cnt`, and go to RUN.
  - RUN: each cycle apply R_PER_CLK steps and increment `cnt`. On the cycle where `cnt`=N−1 (after that update), go to DONE.
  - DONE: `out_valid`=1 and `out_data`=`s`. Hold until `out_ready`=1, then go to IDLE.
- `in_ready` is 0 in RUN and DONE. A word offered then is not consumed and must be held by upstream.
- Changes on `in_data`/`in_inv` outside the accept cycle have no effect.
- `out_data` is driven from `s` continuously. It is meaningful only while `out_valid`=1, and is stable for the entire DONE hold.
- Illegal `R_PER_CLK` values are a synthesis-time error (generate-time check).

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0 (`s` cleared), `cnt`=0, `inv`=0.
- Reset asserted mid-RUN or mid-DONE aborts immediately and asynchronously. The partial result is discarded and nothing is emitted.
- Latency: accept at edge E. `out_valid` rises after edge E+N. N=16 at default.
- Output handshake completes at the first edge with `out_valid`&&`out_ready`. `in_ready` rises in the following cycle.
- Throughput: one word per N+2 cycles when `out_ready` is held high, i.e. 18 cycles at default.
- `out_ready` high before DONE is ignored. DONE lasts at least one full cycle.
- `in_valid` and `out_ready` arriving in the same cycle: nothing special, because the two handshakes live in different states.
- Critical path is R_PER_CLK chained l-evaluations, each a 16-input XOR tree of constant multipliers.

## Test plan
- Single R, forward: force state 00000000000000000000000000000100 and check one R-step gives 94000000000000000000000000000001. Continuing, R steps 2–4 give:
  - step 2: a5940000000000000000000000000000
  - step 3: 64a59400000000000000000000000000
  - step 4: 0d64a594000000000000000000000000

  Check each through a debug tap or an `R_PER_CLK`=1 waveform.
- Full L: `in_data`=64a59400000000000000000000000000, `in_inv`=0 gives `out_data`=d456584dd0e3e84cc3166e4b7fa2890d, with `out_valid` exactly 16 cycles after accept. Chained input d456584dd0e3e84cc3166e4b7fa2890d gives 79d26221b87b584cd42fbc4ffea5de9a.
- Inverse: `in_data`=d456584dd0e3e84cc3166e4b7fa2890d, `in_inv`=1 gives 64a59400000000000000000000000000.
- Parameter sweep: repeat the above with `R_PER_CLK` = 2, 4, 8, 16. Results are identical; latency is 8, 4, 2 and 1 cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. Required: `out_valid` stays 1, `out_data` is stable, `in_ready` stays 0, and a second `in_valid` is not accepted until the cycle after the output handshake.
- Reset mid-RUN: deassert `rst_n` at cycle 7 of RUN. Required: `out_valid`=0, `out_data`=0 and `in_ready`=1 immediately. After release, a new word completes correctly with full latency.
